// File: rtl/ram_if_pkg.sv
// Shared definitions for the cache-to-RAM line interface: default widths,
// beats per line and the responder FSM state encoding.
package ram_if_pkg;

    localparam int RAM_ADDR_SIZE_DEF   = 13;
    localparam int RAM_WORD_SIZE_DEF   = 16;
    localparam int CACHE_STR_WIDTH_DEF = 64;
    localparam int RD_LATENCY_DEF      = 4;
    localparam int BEATS               = CACHE_STR_WIDTH_DEF / RAM_WORD_SIZE_DEF;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_COLLECT = 3'd1,
        RD_WAIT    = 3'd2,
        RD_BURST   = 3'd3,
        WR_ACK     = 3'd4
    } ram_state_t;

endpackage

// File: rtl/ram_resp_store.sv
// Line storage for the RAM responder: one line-wide write port, combinational
// read, and per-line written flags so untouched lines return an address pattern.
module ram_resp_store #(
    parameter int ADDR_W = 13,
    parameter int WORD_W = 16,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [LINE_W-1:0] wline,
    input  logic [ADDR_W-1:0] raddr,
    output logic [LINE_W-1:0] rline
);

    localparam int DEPTH     = 1 << ADDR_W;
    localparam int NUM_BEATS = LINE_W / WORD_W;

    logic [LINE_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written_reg;
    logic [LINE_W-1:0] pattern_line;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wline;
        end
    end

    // Only the flags are reset; the array contents are masked until rewritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_reg <= '0;
        end else if (we) begin
            written_reg[waddr] <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BEATS; gi++) begin : g_pattern
            localparam logic [1:0] BEAT_IDX = 2'(gi);
            logic [WORD_W-1:0] pat_beat;

            always_comb begin
                pat_beat               = '0;
                pat_beat[WORD_W-3:0]   = (WORD_W-2)'(raddr);
                pat_beat[WORD_W-1 -: 2] = BEAT_IDX;
            end

            assign pattern_line[gi*WORD_W +: WORD_W] = pat_beat;
        end
    endgenerate

    assign rline = written_reg[raddr] ? mem[raddr] : pattern_line;

endmodule

// File: rtl/ram_responder.sv
// Line-oriented RAM model answering cache read/write bursts with fixed read latency.
// Optional RAM_RESP_BACKDOOR_EN adds data_backdoor, the last committed write line.
module ram_responder
    import ram_if_pkg::*;
#(
    parameter int RAM_ADDR_SIZE   = RAM_ADDR_SIZE_DEF,
    parameter int RAM_WORD_SIZE   = RAM_WORD_SIZE_DEF,
    parameter int CACHE_STR_WIDTH = CACHE_STR_WIDTH_DEF,
    parameter int RD_LATENCY      = RD_LATENCY_DEF
) (
    input  logic                       ram_clk,
    input  logic                       ram_rst_n,
    input  logic                       ram_avalid,
    input  logic                       ram_rnw,
    input  logic [RAM_ADDR_SIZE-1:0]   ram_addr,
    input  logic [RAM_WORD_SIZE-1:0]   ram_wdata,
    output logic [RAM_WORD_SIZE-1:0]   ram_rdata,
    output logic                       ram_rack
`ifdef RAM_RESP_BACKDOOR_EN
    ,
    output logic [CACHE_STR_WIDTH-1:0] data_backdoor
`endif
);

    localparam int NUM_BEATS = CACHE_STR_WIDTH / RAM_WORD_SIZE;
    localparam int BEAT_W    = $clog2(NUM_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    // Last RD_WAIT count; unused when RD_LATENCY is 1 (IDLE jumps straight to RD_BURST).
    localparam logic [3:0] WAIT_LAST = 4'(RD_LATENCY - 2);

    ram_state_t                 state_reg;
    logic [RAM_ADDR_SIZE-1:0]   addr_reg;
    logic [BEAT_W-1:0]          beat_cnt_reg;
    logic [BEAT_W-1:0]          beat_next;
    logic [3:0]                 wait_cnt_reg;
    logic [CACHE_STR_WIDTH-1:0] line_buf_reg;

    logic                       store_we;
    logic [RAM_ADDR_SIZE-1:0]   store_raddr;
    logic [CACHE_STR_WIDTH-1:0] store_rline;

    // In IDLE the store looks at the live request address so a latency-1 read
    // can present beat 0 on the very next cycle.
    assign store_we    = (state_reg == WR_ACK);
    assign store_raddr = (state_reg == IDLE) ? ram_addr : addr_reg;
    assign beat_next   = beat_cnt_reg + 1'b1;

    ram_resp_store #(
        .ADDR_W (RAM_ADDR_SIZE),
        .WORD_W (RAM_WORD_SIZE),
        .LINE_W (CACHE_STR_WIDTH)
    ) u_store (
        .clk   (ram_clk),
        .rst_n (ram_rst_n),
        .we    (store_we),
        .waddr (addr_reg),
        .wline (line_buf_reg),
        .raddr (store_raddr),
        .rline (store_rline)
    );

    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            beat_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            line_buf_reg <= '0;
            ram_rack     <= 1'b0;
            ram_rdata    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ram_rack     <= 1'b0;
                    ram_rdata    <= '0;
                    beat_cnt_reg <= '0;
                    wait_cnt_reg <= '0;
                    if (ram_avalid) begin
                        addr_reg <= ram_addr;
                        if (ram_rnw) begin
                            if (RD_LATENCY == 1) begin
                                state_reg <= RD_BURST;
                                ram_rack  <= 1'b1;
                                ram_rdata <= store_rline[RAM_WORD_SIZE-1:0];
                            end else begin
                                state_reg <= RD_WAIT;
                            end
                        end else begin
                            // The request cycle already carries beat 0.
                            line_buf_reg[RAM_WORD_SIZE-1:0] <= ram_wdata;
                            beat_cnt_reg <= BEAT_W'(1);
                            state_reg    <= WR_COLLECT;
                        end
                    end
                end

                WR_COLLECT: begin
                    line_buf_reg[beat_cnt_reg*RAM_WORD_SIZE +: RAM_WORD_SIZE] <= ram_wdata;
                    if (beat_cnt_reg == LAST_BEAT) begin
                        beat_cnt_reg <= '0;
                        ram_rack     <= 1'b1;
                        state_reg    <= WR_ACK;
                    end else begin
                        beat_cnt_reg <= beat_next;
                    end
                end

                WR_ACK: begin
                    ram_rack  <= 1'b0;
                    state_reg <= IDLE;
                end

                RD_WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        wait_cnt_reg <= '0;
                        ram_rack     <= 1'b1;
                        ram_rdata    <= store_rline[RAM_WORD_SIZE-1:0];
                        state_reg    <= RD_BURST;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end

                RD_BURST: begin
                    if (beat_cnt_reg == LAST_BEAT) begin
                        beat_cnt_reg <= '0;
                        ram_rack     <= 1'b0;
                        ram_rdata    <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        beat_cnt_reg <= beat_next;
                        ram_rdata    <= store_rline[beat_next*RAM_WORD_SIZE +: RAM_WORD_SIZE];
                    end
                end

                default: begin
                    ram_rack  <= 1'b0;
                    ram_rdata <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_RESP_BACKDOOR_EN
    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            data_backdoor <= '0;
        end else if (state_reg == WR_ACK) begin
            data_backdoor <= line_buf_reg;
        end
    end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a transaction-level model predicts rack/rdata
// per cycle, plus literal beat checks for the documented scenarios.
module tb_ram_responder;

    parameter int LAT = 4;
    localparam int A  = 13;
    localparam int W  = 16;
    localparam int L  = 64;
    localparam int NB = 4;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         avalid = 1'b0;
    logic         rnw    = 1'b0;
    logic [A-1:0] addr   = '0;
    logic [W-1:0] wdata  = '0;
    logic [W-1:0] rdata;
    logic         rack;
`ifdef RAM_RESP_BACKDOOR_EN
    logic [L-1:0] backdoor;
`endif

    ram_responder #(
        .RAM_ADDR_SIZE   (A),
        .RAM_WORD_SIZE   (W),
        .CACHE_STR_WIDTH (L),
        .RD_LATENCY      (LAT)
    ) dut (
        .ram_clk    (clk),
        .ram_rst_n  (rst_n),
        .ram_avalid (avalid),
        .ram_rnw    (rnw),
        .ram_addr   (addr),
        .ram_wdata  (wdata),
        .ram_rdata  (rdata),
        .ram_rack   (rack)
`ifdef RAM_RESP_BACKDOOR_EN
        ,
        .data_backdoor (backdoor)
`endif
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state: committed lines, per-cycle expected outputs, busy horizon.
    logic [L-1:0] mem_m   [int];
    bit           exp_rack[longint];
    logic [W-1:0] exp_rd  [longint];
    longint       busy_until = -1;
    logic [W-1:0] got_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [L-1:0] model_line(input int a);
        logic [L-1:0] line;
        if (mem_m.exists(a)) return mem_m[a];
        for (int i = 0; i < NB; i++) line[i*W +: W] = W'(i * 16384 + a);
        return line;
    endfunction

    // Returns 1 if the request issued in cycle t is accepted.
    function automatic bit model_accept(input longint t, input bit is_rd, input int a,
                                        input logic [L-1:0] line);
        logic [L-1:0] rl;
        if (t <= busy_until) return 1'b0;
        if (is_rd) begin
            rl = model_line(a);
            for (int k = 0; k < NB; k++) begin
                exp_rack[t+LAT+k] = 1'b1;
                exp_rd[t+LAT+k]   = rl[k*W +: W];
            end
            busy_until = t + LAT + NB - 1;
        end else begin
            exp_rack[t+NB] = 1'b1;
            exp_rd[t+NB]   = '0;
            mem_m[a]       = line;
            busy_until     = t + NB;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        mem_m.delete();
        exp_rack.delete();
        exp_rd.delete();
        busy_until = -1;
    endfunction

    always @(negedge clk) begin
        bit           er;
        logic [W-1:0] ed;
        er = exp_rack.exists(cyc) ? exp_rack[cyc] : 1'b0;
        ed = exp_rd.exists(cyc) ? exp_rd[cyc] : '0;
        check("rack", 64'(rack), 64'(er));
        check("rdata", 64'(rdata), 64'(ed));
        if (rack) got_q.push_back(rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [A-1:0] a, input bit clear);
        bit acc;
        step();
        avalid = 1'b1;
        rnw    = 1'b1;
        addr   = a;
        if (clear) got_q.delete();
        acc = model_accept(cyc, 1'b1, int'(a), '0);
        $display("read   addr=%h cycle=%0d accepted=%0d", a, cyc, acc);
        step();
        avalid = 1'b0;
    endtask

    task automatic do_write(input logic [A-1:0] a, input logic [L-1:0] line);
        bit acc;
        step();
        avalid = 1'b1;
        rnw    = 1'b0;
        addr   = a;
        wdata  = line[W-1:0];
        acc = model_accept(cyc, 1'b0, int'(a), line);
        $display("write  addr=%h line=%h cycle=%0d accepted=%0d", a, line, cyc, acc);
        for (int k = 1; k < NB; k++) begin
            step();
            avalid = 1'b0;
            wdata  = line[k*W +: W];
        end
        step();
        wdata = '0;
    endtask

    task automatic check_beats(input string name, input logic [63:0] exp_line);
        logic [W-1:0] b;
        check({name, "_count"}, 64'(got_q.size()), 64'(NB));
        for (int k = 0; k < NB; k++) begin
            b = (k < got_q.size()) ? got_q[k] : 'x;
            check(name, 64'(b), 64'(exp_line[k*W +: W]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [L-1:0] line;
        bit           acc;

        // Reset state
        repeat (3) step();
        check("reset_rack", 64'(rack), 64'd0);
        check("reset_rdata", 64'(rdata), 64'd0);
`ifdef RAM_RESP_BACKDOOR_EN
        check("reset_backdoor", backdoor, 64'd0);
`endif
        rst_n = 1'b1;

        // Unwritten line returns the address pattern
        line = model_line(13'h0ABC);
        check("model_pattern", line, 64'hCABC_8ABC_4ABC_0ABC);
        do_read(13'h0ABC, 1'b1);
        repeat (LAT + NB) step();
        check_beats("rd_0abc", 64'hCABC_8ABC_4ABC_0ABC);

        // Write, then read the same line the cycle after the ack
        do_write(13'h0BBC, 64'hDEAD_BEEF_1000_9BBC);
        do_read(13'h0BBC, 1'b1);
        repeat (LAT + NB) step();
        check_beats("rd_0bbc", 64'hDEAD_BEEF_1000_9BBC);
`ifdef RAM_RESP_BACKDOOR_EN
        check("backdoor", backdoor, 64'hDEAD_BEEF_1000_9BBC);
`endif

        // Request during a burst is ignored; next request back-to-back
        do_read(13'h0200, 1'b1);
        repeat (LAT) step();
        avalid = 1'b1;
        rnw    = 1'b1;
        addr   = 13'h0001;
        acc = model_accept(cyc, 1'b1, 1, '0);
        $display("read   addr=%h cycle=%0d accepted=%0d (during burst)", addr, cyc, acc);
        step();
        avalid = 1'b0;
        step();
        do_read(13'h0300, 1'b0);
        repeat (LAT + NB) step();
        check("b2b_count", 64'(got_q.size()), 64'd8);
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            logic [W-1:0] e;
            e = W'((k % 4) * 16384 + ((k < 4) ? 'h200 : 'h300));
            check("b2b_beat", 64'(got_q[k]), 64'(e));
        end

        // Reset after two write beats aborts the write
        step();
        avalid = 1'b1;
        rnw    = 1'b0;
        addr   = 13'h0100;
        wdata  = 16'h1111;
        $display("write  addr=%h partial, reset after 2 beats cycle=%0d", addr, cyc);
        step();
        avalid = 1'b0;
        wdata  = 16'h2222;
        step();
        rst_n  = 1'b0;
        wdata  = '0;
        model_reset();
        #1;
        check("abort_rack", 64'(rack), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        do_read(13'h0100, 1'b1);
        repeat (LAT + NB) step();
        check_beats("rd_0100", 64'hC100_8100_4100_0100);

        // Reset also forgets the earlier write to 0x0BBC
        do_read(13'h0BBC, 1'b1);
        repeat (LAT + NB) step();
        check_beats("rd_0bbc_after_rst", 64'hCBBC_8BBC_4BBC_0BBC);

        // Top address write/read, then address 0
        do_write(13'h1FFF, 64'h0123_4567_89AB_CDEF);
        do_read(13'h1FFF, 1'b1);
        repeat (LAT + NB) step();
        check_beats("rd_1fff", 64'h0123_4567_89AB_CDEF);
        do_read(13'h0000, 1'b1);
        repeat (LAT + NB) step();
        check_beats("rd_0000", 64'hC000_8000_4000_0000);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
